cache_ctrl: RTL and testbench
=============================

// Module: cache_ctrl
// PURPOSE
//  Cache management FSM between the CPU memory stage, the 2-way LRU data cache and main memory.
//  Drives the cache's load/edit/store/invalid controls and stalls the CPU on a miss.
//  Writes a dirty LRU victim back to memory, then refills the 4-word line one word per memory ack.
//  Releases the stall once a re-probe of the cache hits.
// PARAMETERS
//  ADDR_BITS            32  byte address width
//  TAG_BITS             23  tag field, addr[31:9]
//  SET_INDEX_WIDTH       5  set index, addr[8:4]
//  ELEMENT_WORDS_WIDTH   2  word-in-line, addr[3:2]; a line is 4 words
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous active-high reset
//  addr_rw      in   32  CPU byte address; held stable while stall=1
//  en_r         in   1   CPU load request
//  en_w         in   1   CPU store request; has priority over en_r
//  u_b_h_w      in   3   RV32I width/sign code, passed to the cache
//  data_w       in   32  CPU store data
//  data_r       out  32  CPU load data
//  stall        out  1   CPU must hold its request
//  c_addr       out  32  cache address
//  c_load       out  1   cache load (updates recent)
//  c_edit       out  1   cache edit (CPU write)
//  c_store      out  1   cache store (refill word)
//  c_invalid    out  1   cache invalidate set
//  c_din        out  32  cache write data
//  c_u_b_h_w    out  3   cache width code
//  c_dout       in   32  cache read data, registered, 1-cycle latency
//  c_hit, c_valid, c_dirty   in  1 each   registered cache status of the LRU victim way
//  c_tag        in   23  registered LRU victim tag
//  mem_cs       out  1   memory request
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word-aligned memory address
//  mem_dout     out  32  memory write data
//  mem_din      in   32  memory read data, valid when mem_ack=1
//  mem_ack      in   1   one-cycle acknowledge; arrives >=1 cycle after mem_cs rises
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; data_r, mem_*, c_load/edit/store cleared; stall=0.
//   While rst=1: c_invalid=1 and c_addr=latched request address, so an interrupted line's set is invalidated.
//  States: IDLE, CHECK, BK_RD, BK_WR, FILL, WAIT. cnt is a 2-bit word counter.
//  IDLE, request present (en_r|en_w):
//   c_addr=addr_rw, c_load=en_r&~en_w, c_edit=en_w, c_din=data_w.
//   Latch addr_rw into req_addr. Next state is CHECK.
//  CHECK (cache status now valid):
//   c_hit=1: data_r<=c_dout for loads; go to IDLE. stall=0 in this cycle.
//   miss with c_valid&c_dirty: latch vtag=c_tag; cnt=0; go to BK_RD.
//   other miss: cnt=0; go to FILL.
//   No c_load/c_edit/c_store is issued in CHECK.
//  BK_RD: c_addr={vtag,idx,cnt,2'b00}, all cache strobes 0 (no recent update). Next state is BK_WR.
//  BK_WR: mem_cs=1, mem_we=1, mem_addr={vtag,idx,cnt,00}, mem_dout=c_dout held from BK_RD.
//   On mem_ack: cnt++. If cnt was 3, cnt wraps to 0 and go to FILL; otherwise go to BK_RD.
//  FILL: mem_cs=1, mem_we=0, mem_addr={req_tag,idx,cnt,00}.
//   On mem_ack, same cycle: c_store=1, c_addr=mem_addr, c_din=mem_din, cnt++.
//   After the ack with cnt=3, go to WAIT.
//   recent bits are untouched during a fill, so all 4 words land in the same way.
//  WAIT: one bubble, then IDLE; the still-held request re-probes and hits. An en_w re-probe sets dirty.
//  stall = (en_r|en_w) & ~(state==CHECK & c_hit).
//  Line round trip on a miss: 2 + (dirty ? 4*(1+ackdelay) : 0) + 4*ackdelay + 1 + 2 cycles.
//  Request dropped mid-miss: the line fill still completes; no CPU-side effect.
//  mem_cs falls in the cycle after the final ack. No back-to-back requests are issued without an IDLE.
// TESTING
//  1 Cold LW 0x104. Memory holds 0x11,0x22,0x33,0x44 at 0x100..0x10C, ack delay 2.
//    -> 4 reads in address order, mem_we never 1, data_r=0x22, stall falls on re-probe CHECK.
//  2 Repeat LW 0x104 -> stall high for exactly 1 cycle (IDLE), mem_cs stays 0, data_r=0x22.
//  3 SB 0xAB to 0x105, then LW 0x304, then LW 0x504 (same set 0x10).
//    -> third access writes back 0x100..0x10C with word 0x104=0x0000AB22, then refills from 0x500.
//  4 Word 0x000080FF at 0x200: LB 0x201 -> data_r=0xFFFFFF80; LBU 0x201 -> 0x00000080.
//  5 rst high after the 2nd FILL ack of LW 0x704.
//    -> next cycle mem_cs=0, state IDLE, c_invalid=1 for set 0x10; LW 0x704 then refetches all 4 words.

Source files
------------

// File: rtl/cache_ctrl.sv
// Cache management FSM between the CPU memory stage, a 2-way LRU data cache and main memory.
// Probes the cache, writes back a dirty victim line, refills the line word by word, then re-probes.
module cache_ctrl #(
  parameter int ADDR_BITS           = 32,
  parameter int TAG_BITS            = 23,
  parameter int SET_INDEX_WIDTH     = 5,
  parameter int ELEMENT_WORDS_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  output logic [ADDR_BITS-1:0] c_addr,
  output logic                 c_load,
  output logic                 c_edit,
  output logic                 c_store,
  output logic                 c_invalid,
  output logic [31:0]          c_din,
  output logic [2:0]           c_u_b_h_w,
  input  logic [31:0]          c_dout,
  input  logic                 c_hit,
  input  logic                 c_valid,
  input  logic                 c_dirty,
  input  logic [TAG_BITS-1:0]  c_tag,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_dout,
  input  logic [31:0]          mem_din,
  input  logic                 mem_ack
);

  localparam int IDX_LO = ELEMENT_WORDS_WIDTH + 2;
  localparam int TAG_LO = IDX_LO + SET_INDEX_WIDTH;
  localparam logic [2:0] WIDTH_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_BK_RD,
    S_BK_WR,
    S_FILL,
    S_WAIT
  } state_t;

  state_t                         state_q, state_d;
  logic [ELEMENT_WORDS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]           req_addr_q, req_addr_d;
  logic                           req_we_q, req_we_d;
  logic [TAG_BITS-1:0]            vtag_q, vtag_d;
  logic [31:0]                    data_r_q, data_r_d;
  logic [31:0]                    wb_q, wb_d;
  logic                           wb_first_q, wb_first_d;

  logic [SET_INDEX_WIDTH-1:0]     req_idx;
  logic [TAG_BITS-1:0]            req_tag;
  logic [ADDR_BITS-1:0]           victim_addr;
  logic [ADDR_BITS-1:0]           fill_addr;
  logic                           req;

  function automatic logic [ADDR_BITS-1:0] line_addr(
    input logic [TAG_BITS-1:0]            tag,
    input logic [SET_INDEX_WIDTH-1:0]     idx,
    input logic [ELEMENT_WORDS_WIDTH-1:0] word
  );
    return {tag, idx, word, 2'b00};
  endfunction

  assign req_idx     = req_addr_q[TAG_LO-1:IDX_LO];
  assign req_tag     = req_addr_q[ADDR_BITS-1:TAG_LO];
  assign victim_addr = line_addr(vtag_q, req_idx, cnt_q);
  assign fill_addr   = line_addr(req_tag, req_idx, cnt_q);
  assign req         = en_r | en_w;
  assign data_r      = data_r_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_we_d   = req_we_q;
    vtag_d     = vtag_q;
    data_r_d   = data_r_q;
    wb_d       = wb_q;
    wb_first_d = 1'b0;

    c_addr     = req_addr_q;
    c_load     = 1'b0;
    c_edit     = 1'b0;
    c_store    = 1'b0;
    c_invalid  = 1'b0;
    c_din      = '0;
    c_u_b_h_w  = WIDTH_WORD;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = fill_addr;
    mem_dout   = wb_q;
    stall      = req & ~((state_q == S_CHECK) & c_hit);

    case (state_q)
      S_IDLE: begin
        c_addr    = addr_rw;
        c_u_b_h_w = u_b_h_w;
        c_din     = data_w;
        if (req) begin
          c_load     = en_r & ~en_w;
          c_edit     = en_w;
          req_addr_d = addr_rw;
          req_we_d   = en_w;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        // Status here belongs to the probe issued from IDLE; victim fields describe the LRU way.
        if (c_hit) begin
          if (!req_we_q) data_r_d = c_dout;
          state_d = S_IDLE;
        end else if (c_valid && c_dirty) begin
          vtag_d  = c_tag;
          cnt_d   = '0;
          state_d = S_BK_RD;
        end else begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_BK_RD: begin
        c_addr     = victim_addr;
        wb_first_d = 1'b1;
        state_d    = S_BK_WR;
      end
      S_BK_WR: begin
        // Read data arrives only in the first BK_WR cycle; hold it for the rest of the write.
        c_addr   = victim_addr;
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = victim_addr;
        mem_dout = wb_first_q ? c_dout : wb_q;
        if (wb_first_q) wb_d = c_dout;
        if (mem_ack) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (&cnt_q) ? S_FILL : S_BK_RD;
        end
      end
      S_FILL: begin
        mem_cs = 1'b1;
        c_addr = fill_addr;
        if (mem_ack) begin
          c_store = 1'b1;
          c_din   = mem_din;
          cnt_d   = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset invalidates the set of the last request so a half-filled line is never trusted.
    if (rst) begin
      stall     = 1'b0;
      c_addr    = req_addr_q;
      c_load    = 1'b0;
      c_edit    = 1'b0;
      c_store   = 1'b0;
      c_invalid = 1'b1;
      c_din     = '0;
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_dout  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      data_r_q   <= '0;
      wb_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_r_q   <= data_r_d;
      wb_first_q <= wb_first_d;
      req_addr_q <= req_addr_d;
      req_we_q   <= req_we_d;
      vtag_q     <= vtag_d;
      wb_q       <= wb_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: a behavioural 2-way LRU cache and an acking memory surround the DUT,
// and directed CPU accesses are checked against hand-computed values.
module tb_cache_ctrl;

  localparam int ACK_DLY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_rw;
  logic        en_r, en_w;
  logic [2:0]  u_b_h_w;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;
  logic [31:0] c_addr;
  logic        c_load, c_edit, c_store, c_invalid;
  logic [31:0] c_din;
  logic [2:0]  c_u_b_h_w;
  logic [31:0] c_dout;
  logic        c_hit, c_valid, c_dirty;
  logic [22:0] c_tag;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_ack;

  logic        model_clr;
  int          tests_run = 0;
  int          fails = 0;
  int          cs_cycles = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];

  cache_ctrl dut (
    .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
    .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
    .c_addr(c_addr), .c_load(c_load), .c_edit(c_edit), .c_store(c_store),
    .c_invalid(c_invalid), .c_din(c_din), .c_u_b_h_w(c_u_b_h_w), .c_dout(c_dout),
    .c_hit(c_hit), .c_valid(c_valid), .c_dirty(c_dirty), .c_tag(c_tag),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // ---------------- cache model ----------------
  logic [22:0] ctag [32][2];
  logic        cval [32][2];
  logic        cdir [32][2];
  logic [31:0] cdat [32][2][4];
  logic        clru [32];

  function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] f);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wr_merge(input logic [31:0] w, input logic [31:0] d,
                                           input logic [1:0] off, input logic [2:0] f);
    logic [31:0] m;
    logic [4:0]  sh;
    sh = {off, 3'b000};
    case (f[1:0])
      2'b00:   m = 32'h0000_00FF << sh;
      2'b01:   m = 32'h0000_FFFF << sh;
      default: return d;
    endcase
    return (w & ~m) | ((d << sh) & m);
  endfunction

  always @(posedge clk) begin : cache_model
    logic [4:0]  s;
    logic [1:0]  wd;
    logic [22:0] t;
    logic        v;
    int          hw;
    s  = c_addr[8:4];
    wd = c_addr[3:2];
    t  = c_addr[31:9];
    hw = -1;
    if (model_clr) begin
      for (int i = 0; i < 32; i++) begin
        cval[i][0] = 1'b0; cval[i][1] = 1'b0;
        cdir[i][0] = 1'b0; cdir[i][1] = 1'b0;
        clru[i]    = 1'b0;
      end
      c_hit <= 1'b0; c_valid <= 1'b0; c_dirty <= 1'b0; c_tag <= '0; c_dout <= '0;
    end else begin
      for (int i = 0; i < 2; i++) if (cval[s][i] && ctag[s][i] == t) hw = i;
      v = clru[s];
      c_hit   <= (hw >= 0);
      c_valid <= cval[s][v];
      c_dirty <= cdir[s][v];
      c_tag   <= ctag[s][v];
      c_dout  <= (hw >= 0) ? rd_ext(cdat[s][hw[0]][wd], c_addr[1:0], c_u_b_h_w) : 32'h0;
      if (c_invalid) begin
        cval[s][0] = 1'b0;
        cval[s][1] = 1'b0;
      end else if (c_store) begin
        cdat[s][v][wd] = c_din;
        ctag[s][v]     = t;
        cval[s][v]     = 1'b1;
        cdir[s][v]     = 1'b0;
      end else if (hw >= 0 && (c_load || c_edit)) begin
        clru[s] = (hw == 0) ? 1'b1 : 1'b0;
        if (c_edit) begin
          cdat[s][hw[0]][wd] = wr_merge(cdat[s][hw[0]][wd], c_din, c_addr[1:0], c_u_b_h_w);
          cdir[s][hw[0]]     = 1'b1;
        end
      end
    end
  end

  // ---------------- memory model ----------------
  logic [31:0] mem [1024];
  logic        wr  [1024];
  int          mcnt = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0000_0011;
      32'h104: return 32'h0000_0022;
      32'h108: return 32'h0000_0033;
      32'h10C: return 32'h0000_0044;
      32'h200: return 32'h0000_80FF;
      default: return 32'hC000_0000 | a;
    endcase
  endfunction

  always @(posedge clk) begin : mem_model
    logic [9:0] a;
    a = mem_addr[11:2];
    if (model_clr) begin
      for (int i = 0; i < 1024; i++) wr[i] = 1'b0;
      mem_ack <= 1'b0;
      mcnt    <= 0;
      mem_din <= '0;
    end else if (mem_cs && !mem_ack) begin
      if (mcnt == ACK_DLY - 2) begin
        mem_ack <= 1'b1;
        mcnt    <= 0;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_we ? mem_dout : 32'h0);
        if (mem_we) begin
          mem[a] = mem_dout;
          wr[a]  = 1'b1;
        end else begin
          mem_din <= wr[a] ? mem[a] : init_val(mem_addr);
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mem_ack <= 1'b0;
      mcnt    <= 0;
    end
  end

  always @(posedge clk) if (mem_cs) cs_cycles <= cs_cycles + 1;

  // Drive one CPU access, hold it while stalled, release after the completing edge.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int sc);
    @(negedge clk);
    en_r = ~we; en_w = we; addr_rw = a; u_b_h_w = f3; data_w = wd;
    #1;
    sc = 0;
    while (stall && sc < 200) begin
      sc++;
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    en_r = 1'b0; en_w = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; model_clr = 1'b1;
    en_r = 1'b0; en_w = 1'b0; addr_rw = '0; u_b_h_w = 3'b010; data_w = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", stall); end
    tests_run++; if (mem_cs !== 1'b0) begin fails++; $display("FAIL rst_mem_cs: got %b want 0", mem_cs); end
    tests_run++; if (c_invalid !== 1'b1) begin fails++; $display("FAIL rst_c_invalid: got %b want 1", c_invalid); end
    tests_run++; if (c_load !== 1'b0 || c_store !== 1'b0 || c_edit !== 1'b0) begin
      fails++; $display("FAIL rst_strobes: got %b%b%b want 000", c_load, c_edit, c_store); end
    tests_run++; if (data_r !== 32'h0) begin fails++; $display("FAIL rst_data_r: got %h want 0", data_r); end
    rst = 1'b0; model_clr = 1'b0;
    @(negedge clk);
    tests_run++; if (c_invalid !== 1'b0) begin fails++; $display("FAIL idle_c_invalid: got %b want 0", c_invalid); end
  endtask

  task automatic test_cold_load;
    int sc, b;
    b = log_addr.size();
    access(1'b0, 3'b010, 32'h104, 32'h0, sc);
    tests_run++; if (sc !== 12) begin fails++; $display("FAIL cold_stall_cycles: got %0d want 12", sc); end
    tests_run++; if (data_r !== 32'h22) begin fails++; $display("FAIL cold_data_r: got %h want 00000022", data_r); end
    tests_run++; if (log_addr.size() - b !== 4) begin fails++; $display("FAIL cold_mem_ops: got %0d want 4", log_addr.size() - b); end
    for (int i = 0; i < 4 && b + i < log_addr.size(); i++) begin
      tests_run++; if (log_we[b+i] !== 1'b0 || log_addr[b+i] !== 32'h100 + 32'(4*i)) begin
        fails++; $display("FAIL cold_read_%0d: got we=%b addr=%h want we=0 addr=%h", i, log_we[b+i], log_addr[b+i], 32'h100 + 32'(4*i)); end
    end
  endtask

  task automatic test_repeat_hit;
    int sc, cs0;
    cs0 = cs_cycles;
    access(1'b0, 3'b010, 32'h104, 32'h0, sc);
    tests_run++; if (sc !== 1) begin fails++; $display("FAIL hit_stall_cycles: got %0d want 1", sc); end
    tests_run++; if (cs_cycles !== cs0) begin fails++; $display("FAIL hit_mem_cs: got %0d cycles want 0", cs_cycles - cs0); end
    tests_run++; if (data_r !== 32'h22) begin fails++; $display("FAIL hit_data_r: got %h want 00000022", data_r); end
  endtask

  task automatic test_dirty_evict;
    int sc, b;
    logic [31:0] exp_wb [4];
    exp_wb = '{32'h0000_0011, 32'h0000_AB22, 32'h0000_0033, 32'h0000_0044};
    access(1'b1, 3'b000, 32'h105, 32'h0000_00AB, sc);
    tests_run++; if (sc !== 1) begin fails++; $display("FAIL sb_stall_cycles: got %0d want 1", sc); end
    b = log_addr.size();
    access(1'b0, 3'b010, 32'h304, 32'h0, sc);
    tests_run++; if (sc !== 12) begin fails++; $display("FAIL lw304_stall_cycles: got %0d want 12", sc); end
    tests_run++; if (data_r !== 32'hC000_0304) begin fails++; $display("FAIL lw304_data_r: got %h want c0000304", data_r); end
    tests_run++; if (log_addr.size() - b !== 4 || log_we[b] !== 1'b0) begin
      fails++; $display("FAIL lw304_clean_fill: got %0d ops want 4 reads", log_addr.size() - b); end
    b = log_addr.size();
    access(1'b0, 3'b010, 32'h504, 32'h0, sc);
    tests_run++; if (sc !== 24) begin fails++; $display("FAIL lw504_stall_cycles: got %0d want 24", sc); end
    tests_run++; if (data_r !== 32'hC000_0504) begin fails++; $display("FAIL lw504_data_r: got %h want c0000504", data_r); end
    tests_run++; if (log_addr.size() - b !== 8) begin fails++; $display("FAIL lw504_mem_ops: got %0d want 8", log_addr.size() - b); end
    for (int i = 0; i < 4 && b + i < log_addr.size(); i++) begin
      tests_run++; if (log_we[b+i] !== 1'b1 || log_addr[b+i] !== 32'h100 + 32'(4*i) || log_data[b+i] !== exp_wb[i]) begin
        fails++; $display("FAIL wb_word_%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i,
                          log_we[b+i], log_addr[b+i], log_data[b+i], 32'h100 + 32'(4*i), exp_wb[i]); end
    end
    for (int i = 0; i < 4 && b + 4 + i < log_addr.size(); i++) begin
      tests_run++; if (log_we[b+4+i] !== 1'b0 || log_addr[b+4+i] !== 32'h500 + 32'(4*i)) begin
        fails++; $display("FAIL refill_%0d: got we=%b addr=%h want we=0 addr=%h", i,
                          log_we[b+4+i], log_addr[b+4+i], 32'h500 + 32'(4*i)); end
    end
  endtask

  task automatic test_byte_load;
    int sc;
    access(1'b0, 3'b000, 32'h201, 32'h0, sc);
    tests_run++; if (sc !== 12) begin fails++; $display("FAIL lb_stall_cycles: got %0d want 12", sc); end
    tests_run++; if (data_r !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_data_r: got %h want ffffff80", data_r); end
    access(1'b0, 3'b100, 32'h201, 32'h0, sc);
    tests_run++; if (sc !== 1) begin fails++; $display("FAIL lbu_stall_cycles: got %0d want 1", sc); end
    tests_run++; if (data_r !== 32'h0000_0080) begin fails++; $display("FAIL lbu_data_r: got %h want 00000080", data_r); end
  endtask

  task automatic test_reset_mid_fill;
    int acks, sc, b;
    @(negedge clk);
    en_r = 1'b1; en_w = 1'b0; addr_rw = 32'h704; u_b_h_w = 3'b010;
    acks = 0;
    for (int i = 0; i < 100 && acks < 2; i++) begin
      @(negedge clk); #1;
      if (mem_cs && !mem_we && mem_ack) acks++;
    end
    tests_run++; if (acks !== 2) begin fails++; $display("FAIL midfill_acks: got %0d want 2", acks); end
    @(posedge clk); #1;
    rst = 1'b1;
    b = log_addr.size();
    #1;
    tests_run++; if (mem_cs !== 1'b0) begin fails++; $display("FAIL midrst_mem_cs: got %b want 0", mem_cs); end
    tests_run++; if (c_invalid !== 1'b1 || c_addr[8:4] !== 5'h10) begin
      fails++; $display("FAIL midrst_invalidate: got inv=%b set=%h want inv=1 set=10", c_invalid, c_addr[8:4]); end
    tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL midrst_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests_run++; if (stall !== 1'b1 || mem_cs !== 1'b0 || c_load !== 1'b1) begin
      fails++; $display("FAIL postrst_idle: got stall=%b cs=%b load=%b want 1 0 1", stall, mem_cs, c_load); end
    tests_run++; if (data_r !== 32'h0) begin fails++; $display("FAIL postrst_data_r: got %h want 0", data_r); end
    sc = 0;
    while (stall && sc < 200) begin
      sc++;
      @(posedge clk); #1;
    end
    tests_run++; if (sc !== 12) begin fails++; $display("FAIL refetch_stall_cycles: got %0d want 12", sc); end
    @(posedge clk); #1;
    en_r = 1'b0;
    tests_run++; if (data_r !== 32'hC000_0704) begin fails++; $display("FAIL refetch_data_r: got %h want c0000704", data_r); end
    tests_run++; if (log_addr.size() - b !== 4) begin fails++; $display("FAIL refetch_ops: got %0d want 4", log_addr.size() - b); end
    for (int i = 0; i < 4 && b + i < log_addr.size(); i++) begin
      tests_run++; if (log_we[b+i] !== 1'b0 || log_addr[b+i] !== 32'h700 + 32'(4*i)) begin
        fails++; $display("FAIL refetch_%0d: got we=%b addr=%h want we=0 addr=%h", i, log_we[b+i], log_addr[b+i], 32'h700 + 32'(4*i)); end
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_repeat_hit();
    test_dirty_evict();
    test_byte_load();
    test_reset_mid_fill();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1);
  end

endmodule
